iob_native_arbiter: RTL and testbench

- Shares one IOb native subordinate (e.g. a CSR block) among N_MANAGERS IOb native managers.
- Round-robin grant; at most one transaction outstanding.
- Holds ownership from request acceptance until write acceptance or read data return, then re-arbitrates.
- Sits between simulation/SoC managers (testbench driver, CPU, DMA) and the shared UUT/CSR port.

---
 rtl/iob_native_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_iob_native_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_native_arbiter.sv
// ---------------------------------------------------------------------------
// iob_native_arbiter
//
// Purpose:
//   This block shares one IOb native subordinate, such as a CSR block, among
//   N_MANAGERS IOb native managers. Grants are round-robin, and only one
//   transaction is outstanding at a time.
//
//   A manager owns the subordinate from the cycle it is granted until its
//   write is accepted or its read data comes back. The arbiter then returns
//   to IDLE and arbitrates again, starting the search at owner+1.
//
// Optional feature (macro IOB_NATIVE_ARBITER_TIMEOUT_EN):
//   Adds a read-data watchdog. If s_rvalid_i has not arrived after
//   TIMEOUT_CYCLES enabled cycles in WAIT_RDATA, the arbiter does three
//   things:
//     - returns 32'hDEADBEEF (low DATA_W bits) to the owner for one cycle;
//     - goes back to IDLE;
//     - sets the sticky timeout_o port.
//   Without the macro there is no timeout_o port, and WAIT_RDATA waits
//   forever.
//
// Ports:
//   clk_i, arst_n_i, cke_i   clock, async active-low reset, clock enable
//   m_valid_i  [N]           per-manager request valid
//   m_addr_i   [N*ADDR_W]    packed addresses, manager k at [k*ADDR_W +: ADDR_W]
//   m_wdata_i  [N*DATA_W]    packed write data
//   m_wstrb_i  [N*DATA_W/8]  packed byte strobes; all-zero means read
//   m_ready_o  [N]           per-manager ready (owner only)
//   m_rvalid_o [N]           per-manager read-data valid (owner only)
//   m_rdata_o  [DATA_W]      read data, broadcast
//   s_*                      shared subordinate port
//   grant_o    [N]           one-hot current owner, 0 when idle
//   busy_o                   high in ACCESS or WAIT_RDATA
//   timeout_o                sticky watchdog flag (optional feature only)
// ---------------------------------------------------------------------------
module iob_native_arbiter #(
   parameter int N_MANAGERS     = 2,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                           clk_i,
   input  logic                           arst_n_i,
   input  logic                           cke_i,
   input  logic [N_MANAGERS-1:0]          m_valid_i,
   input  logic [N_MANAGERS*ADDR_W-1:0]   m_addr_i,
   input  logic [N_MANAGERS*DATA_W-1:0]   m_wdata_i,
   input  logic [N_MANAGERS*DATA_W/8-1:0] m_wstrb_i,
   output logic [N_MANAGERS-1:0]          m_ready_o,
   output logic [N_MANAGERS-1:0]          m_rvalid_o,
   output logic [DATA_W-1:0]              m_rdata_o,
   output logic                           s_valid_o,
   output logic [ADDR_W-1:0]              s_addr_o,
   output logic [DATA_W-1:0]              s_wdata_o,
   output logic [DATA_W/8-1:0]            s_wstrb_o,
   input  logic                           s_ready_i,
   input  logic                           s_rvalid_i,
   input  logic [DATA_W-1:0]              s_rdata_i,
   output logic [N_MANAGERS-1:0]          grant_o,
   output logic                           busy_o
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
   ,
   output logic                           timeout_o
`endif
);

   localparam int IDX_W  = $clog2(N_MANAGERS);
   localparam int STRB_W = DATA_W / 8;
   localparam logic [N_MANAGERS-1:0] ONE_HOT0 = N_MANAGERS'(1);

   if (N_MANAGERS < 2 || N_MANAGERS > 8 || (DATA_W % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("iob_native_arbiter: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT_RDATA
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   next_ptr;
   logic [IDX_W-1:0]   req_idx;
   logic               req_any;

   logic               own_valid;
   logic [ADDR_W-1:0]  own_addr;
   logic [DATA_W-1:0]  own_wdata;
   logic [STRB_W-1:0]  own_wstrb;
   logic               to_hit;

   // The owner's request fields. They only reach the subordinate in ACCESS.
   assign own_valid = m_valid_i[owner];
   assign own_addr  = m_addr_i[int'(owner)*ADDR_W +: ADDR_W];
   assign own_wdata = m_wdata_i[int'(owner)*DATA_W +: DATA_W];
   assign own_wstrb = m_wstrb_i[int'(owner)*STRB_W +: STRB_W];

   // The next search starts just past the manager that was served last.
   assign next_ptr = (int'(owner) == N_MANAGERS - 1) ? '0 : owner + 1'b1;

`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [DATA_W-1:0] TIMEOUT_RDATA = DATA_W'(32'hDEADBEEF);

   logic [TO_W-1:0] to_cnt;

   // Real read data wins if it shows up in the same cycle as the limit.
   assign to_hit = (state == WAIT_RDATA) && !s_rvalid_i &&
                   (to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
   assign to_hit = 1'b0;
`endif

   // Round-robin search from ptr upward, with wrap.
   // The loop runs downward, so the candidate closest to ptr is written last
   // and wins.
   always_comb begin
      req_any = 1'b0;
      req_idx = ptr;
      for (int i = N_MANAGERS - 1; i >= 0; i--) begin
         if (m_valid_i[(int'(ptr) + i) % N_MANAGERS]) begin
            req_any = 1'b1;
            req_idx = IDX_W'((int'(ptr) + i) % N_MANAGERS);
         end
      end
   end

   // Steer the subordinate and manager responses from the registered state.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the case
      // can leave one unassigned and infer a latch.
      s_valid_o  = 1'b0;
      s_addr_o   = '0;
      s_wdata_o  = '0;
      s_wstrb_o  = '0;
      m_ready_o  = '0;
      m_rvalid_o = '0;
      m_rdata_o  = '0;
      case (state)
         ACCESS: begin
            s_valid_o        = own_valid;
            s_addr_o         = own_addr;
            s_wdata_o        = own_wdata;
            s_wstrb_o        = own_wstrb;
            m_ready_o[owner] = s_ready_i;
         end
         WAIT_RDATA: begin
            m_rvalid_o[owner] = s_rvalid_i;
            m_rdata_o         = s_rdata_i;
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
            if (to_hit) begin
               m_rvalid_o[owner] = 1'b1;
               m_rdata_o         = TIMEOUT_RDATA;
            end
`endif
         end
         default: ;
      endcase
   end

   // Arbitration FSM. While cke_i is low, all state holds.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      // NOTE: state is written with non-blocking assignments only, so every
      // flop samples the values from before the edge and no order between
      // statements matters.
      if (!arst_n_i) begin
         state   <= IDLE;
         owner   <= '0;
         ptr     <= '0;
         grant_o <= '0;
         busy_o  <= 1'b0;
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
         to_cnt    <= '0;
         timeout_o <= 1'b0;
`endif
      end else if (cke_i) begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  owner   <= req_idx;
                  grant_o <= ONE_HOT0 << req_idx;
                  busy_o  <= 1'b1;
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               // An owner that drops valid before ready is abandoned.
               // It is treated like a completed write.
               if (!own_valid || s_ready_i) begin
                  ptr <= next_ptr;
                  if (own_valid && own_wstrb == '0) begin
                     state <= WAIT_RDATA;
                  end else begin
                     state   <= IDLE;
                     grant_o <= '0;
                     busy_o  <= 1'b0;
                  end
               end
            end
            WAIT_RDATA: begin
               if (s_rvalid_i || to_hit) begin
                  state   <= IDLE;
                  grant_o <= '0;
                  busy_o  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               grant_o <= '0;
               busy_o  <= 1'b0;
            end
         endcase
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
         // The count is held at zero outside WAIT_RDATA, which clears it on
         // entry. WAIT_RDATA is left at the limit, so the count cannot wrap.
         if (state == WAIT_RDATA) begin
            to_cnt <= to_cnt + 1'b1;
         end else begin
            to_cnt <= '0;
         end
         if (to_hit) begin
            timeout_o <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_iob_native_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iob_native_arbiter
//
// Self-checking bench for iob_native_arbiter (N_MANAGERS=2, 32-bit, timeout
// limit 16). It runs these sections:
//   - reset state;
//   - a table of per-cycle vectors (single write, read routing, abandon);
//   - hand-written sequences: contention order, stall, clock enable, reset
//     in the middle of a read, and the optional watchdog;
//   - a randomized run checked against a transaction-level round-robin model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iob_native_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   logic              clk_i = 1'b0;
   logic              arst_n_i;
   logic              cke_i;
   logic [N-1:0]      m_valid_i;
   logic [N*AW-1:0]   m_addr_i;
   logic [N*DW-1:0]   m_wdata_i;
   logic [N*SW-1:0]   m_wstrb_i;
   logic [N-1:0]      m_ready_o;
   logic [N-1:0]      m_rvalid_o;
   logic [DW-1:0]     m_rdata_o;
   logic              s_valid_o;
   logic [AW-1:0]     s_addr_o;
   logic [DW-1:0]     s_wdata_o;
   logic [SW-1:0]     s_wstrb_o;
   logic              s_ready_i;
   logic              s_rvalid_i;
   logic [DW-1:0]     s_rdata_i;
   logic [N-1:0]      grant_o;
   logic              busy_o;
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
   logic              timeout_o;
`endif

   logic [AW-1:0] addr_q  [N];
   logic [DW-1:0] wdata_q [N];
   logic [SW-1:0] wstrb_q [N];

   always_comb begin
      for (int k = 0; k < N; k++) begin
         m_addr_i[k*AW +: AW]  = addr_q[k];
         m_wdata_i[k*DW +: DW] = wdata_q[k];
         m_wstrb_i[k*SW +: SW] = wstrb_q[k];
      end
   end

   iob_native_arbiter #(
      .N_MANAGERS    (N),
      .ADDR_W        (AW),
      .DATA_W        (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i     (clk_i),
      .arst_n_i  (arst_n_i),
      .cke_i     (cke_i),
      .m_valid_i (m_valid_i),
      .m_addr_i  (m_addr_i),
      .m_wdata_i (m_wdata_i),
      .m_wstrb_i (m_wstrb_i),
      .m_ready_o (m_ready_o),
      .m_rvalid_o(m_rvalid_o),
      .m_rdata_o (m_rdata_o),
      .s_valid_o (s_valid_o),
      .s_addr_o  (s_addr_o),
      .s_wdata_o (s_wdata_o),
      .s_wstrb_o (s_wstrb_o),
      .s_ready_i (s_ready_i),
      .s_rvalid_i(s_rvalid_i),
      .s_rdata_i (s_rdata_i),
      .grant_o   (grant_o),
      .busy_o    (busy_o)
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
      ,
      .timeout_o (timeout_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Return one step past the active edge. Inputs are driven there, and
   // outputs are sampled one time unit later.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [N-1:0] oh(input int k);
      logic [N-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // Round-robin winner from the rule itself: the first valid at or after p.
   function automatic int rr(input logic [N-1:0] v, input int p);
      for (int i = 0; i < N; i++) begin
         if (v[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic do_reset();
      arst_n_i   = 1'b0;
      cke_i      = 1'b1;
      m_valid_i  = '0;
      s_ready_i  = 1'b0;
      s_rvalid_i = 1'b0;
      for (int k = 0; k < N; k++) wstrb_q[k] = '0;
      repeat (2) @(posedge clk_i);
      #3 arst_n_i = 1'b1;
      tick();
   endtask

   typedef struct {
      logic [N-1:0]  valid;
      logic [SW-1:0] strb0;
      logic [SW-1:0] strb1;
      logic          rdy;
      logic          rv;
      logic [N-1:0]  grant;
      logic          busy;
      logic [N-1:0]  mready;
      logic          svalid;
      logic [N-1:0]  mrvalid;
      logic [AW-1:0] saddr;
      logic [DW-1:0] rdata;
   } vec_t;

   vec_t vecs [14];

   // Reference-model state for the randomized run.
   bit           pend    [N];
   int           waited  [N];
   int           ptr_m;
   bit           rd_out;
   int           rd_owner;
   int           rd_delay;
   bit           resp_now;
   bit           prev_busy;
   logic [N-1:0] prev_valid;
   int           order   [$];
   int           cnt     [N];

   initial begin
      // ---------------- reset state ----------------
      arst_n_i   = 1'b0;
      cke_i      = 1'b1;
      m_valid_i  = '1;
      s_ready_i  = 1'b1;
      s_rvalid_i = 1'b1;
      s_rdata_i  = 32'h12345678;
      for (int k = 0; k < N; k++) begin
         wstrb_q[k] = '0;
         wdata_q[k] = '0;
         addr_q[k]  = '0;
      end
      #7;
      check("reset grant",   grant_o,    '0);
      check("reset busy",    busy_o,     0);
      check("reset s_valid", s_valid_o,  0);
      check("reset m_ready", m_ready_o,  '0);
      check("reset m_rvalid", m_rvalid_o, '0);
      check("reset m_rdata", m_rdata_o,  '0);
`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
      check("reset timeout", timeout_o,  0);
`endif

      // ---------------- table-driven vectors ----------------
      addr_q[0]  = 32'h4;
      addr_q[1]  = 32'h8;
      wdata_q[0] = 32'hA5A5A5A5;
      wdata_q[1] = 32'h5A5A5A5A;
      s_rdata_i  = 32'h12345678;
      //            valid  s0     s1    rdy   rv  | grant busy mready sval mrval saddr rdata
      vecs[0]  = '{2'b01, 4'hF, 4'h0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0};
      vecs[1]  = '{2'b01, 4'hF, 4'h0, 1'b1, 1'b0, 2'b01, 1'b1, 2'b01, 1'b1, 2'b00, 32'h4, 32'h0};
      vecs[2]  = '{2'b00, 4'hF, 4'h0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0};
      vecs[3]  = '{2'b10, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0};
      vecs[4]  = '{2'b10, 4'h0, 4'h0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 1'b1, 2'b00, 32'h8, 32'h0};
      vecs[5]  = '{2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 32'h0, 32'h12345678};
      vecs[6]  = '{2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 2'b10, 32'h0, 32'h12345678};
      vecs[7]  = '{2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0};
      vecs[8]  = '{2'b01, 4'hF, 4'hF, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0};
      vecs[9]  = '{2'b00, 4'hF, 4'hF, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 32'h4, 32'h0};
      vecs[10] = '{2'b11, 4'hF, 4'hF, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0};
      vecs[11] = '{2'b11, 4'hF, 4'hF, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 1'b1, 2'b00, 32'h8, 32'h0};
      vecs[12] = '{2'b11, 4'hF, 4'hF, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 1'b1, 2'b00, 32'h8, 32'h0};
      vecs[13] = '{2'b00, 4'hF, 4'hF, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0};

      do_reset();
      for (int i = 0; i < 14; i++) begin
         m_valid_i  = vecs[i].valid;
         wstrb_q[0] = vecs[i].strb0;
         wstrb_q[1] = vecs[i].strb1;
         s_ready_i  = vecs[i].rdy;
         s_rvalid_i = vecs[i].rv;
         #1;
         check($sformatf("vec%0d grant", i),    grant_o,    vecs[i].grant);
         check($sformatf("vec%0d busy", i),     busy_o,     vecs[i].busy);
         check($sformatf("vec%0d m_ready", i),  m_ready_o,  vecs[i].mready);
         check($sformatf("vec%0d s_valid", i),  s_valid_o,  vecs[i].svalid);
         check($sformatf("vec%0d m_rvalid", i), m_rvalid_o, vecs[i].mrvalid);
         check($sformatf("vec%0d s_addr", i),   s_addr_o,   vecs[i].saddr);
         check($sformatf("vec%0d m_rdata", i),  m_rdata_o,  vecs[i].rdata);
         tick();
      end

      // ---------------- contention: 3 writes each ----------------
      do_reset();
      cnt[0] = 3;
      cnt[1] = 3;
      wstrb_q[0] = 4'hF;
      wstrb_q[1] = 4'hF;
      s_ready_i  = 1'b1;
      order.delete();
      for (int c = 0; c < 60 && order.size() < 6; c++) begin
         for (int k = 0; k < N; k++) m_valid_i[k] = (cnt[k] > 0);
         #1;
         for (int k = 0; k < N; k++) begin
            if (m_ready_o[k] && m_valid_i[k]) begin
               order.push_back(k);
               cnt[k]--;
            end
         end
         tick();
      end
      m_valid_i = '0;
      check("contention count", order.size(), 6);
      for (int i = 0; i < order.size(); i++) begin
         check($sformatf("contention order%0d", i), order[i], i % 2);
      end

      // ---------------- stall: s_ready low 5 cycles ----------------
      do_reset();
      m_valid_i  = 2'b11;
      wstrb_q[0] = 4'hF;
      wstrb_q[1] = 4'hF;
      s_ready_i  = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("stall%0d m_ready", c), m_ready_o, 2'b00);
         check($sformatf("stall%0d s_addr", c),  s_addr_o,  32'h4);
         check($sformatf("stall%0d grant", c),   grant_o,   2'b01);
         tick();
      end
      s_ready_i = 1'b1;
      #1;
      check("stall release m_ready", m_ready_o, 2'b01);
      tick();
      m_valid_i = 2'b10;
      tick();
      #1;
      check("stall next grant", grant_o,   2'b10);
      check("stall next ready", m_ready_o, 2'b10);
      tick();
      m_valid_i = '0;
      s_ready_i = 1'b0;

      // ---------------- clock enable freeze ----------------
      do_reset();
      m_valid_i  = 2'b10;
      wstrb_q[1] = 4'hF;
      cke_i      = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         #1;
         check($sformatf("cke idle%0d grant", c), grant_o, 2'b00);
      end
      cke_i = 1'b1;
      tick();
      #1;
      check("cke granted", grant_o, 2'b10);
      cke_i = 1'b0;
      repeat (2) tick();
      #1;
      check("cke hold grant", grant_o, 2'b10);
      check("cke hold busy",  busy_o,  1);
      cke_i     = 1'b1;
      s_ready_i = 1'b1;
      tick();
      m_valid_i = '0;
      s_ready_i = 1'b0;

      // ---------------- reset in the middle of a read ----------------
      do_reset();
      m_valid_i  = 2'b01;
      wstrb_q[0] = 4'h0;
      s_ready_i  = 1'b1;
      tick();
      tick();
      m_valid_i = '0;
      s_ready_i = 1'b0;
      #1;
      check("midrd busy", busy_o, 1);
      s_rvalid_i = 1'b1;
      m_valid_i  = 2'b11;
      wstrb_q[0] = 4'hF;
      wstrb_q[1] = 4'hF;
      s_ready_i  = 1'b1;
      #1 arst_n_i = 1'b0;
      #1;
      check("midrd rst grant",    grant_o,    '0);
      check("midrd rst busy",     busy_o,     0);
      check("midrd rst m_rvalid", m_rvalid_o, '0);
      check("midrd rst m_rdata",  m_rdata_o,  '0);
      check("midrd rst s_valid",  s_valid_o,  0);
      check("midrd rst m_ready",  m_ready_o,  '0);
      check("midrd rst s_addr",   s_addr_o,   '0);
      #2 arst_n_i = 1'b1;
      s_rvalid_i = 1'b0;
      s_ready_i  = 1'b0;
      tick();
      #1;
      check("midrd regrant ptr0", grant_o, 2'b01);
      m_valid_i = '0;

`ifdef IOB_NATIVE_ARBITER_TIMEOUT_EN
      // ---------------- read-data watchdog ----------------
      begin
         int waitcyc;
         bit found;
         do_reset();
         m_valid_i  = 2'b01;
         wstrb_q[0] = 4'h0;
         s_ready_i  = 1'b1;
         tick();
         tick();
         m_valid_i = '0;
         s_ready_i = 1'b0;
         waitcyc   = 0;
         found     = 1'b0;
         for (int c = 0; c < 40 && !found; c++) begin
            #1;
            if (m_rvalid_o[0]) begin
               found = 1'b1;
               check("timeout rdata",      m_rdata_o, 32'hDEADBEEF);
               check("timeout wait count", waitcyc,   TO);
               check("timeout m_rvalid",   m_rvalid_o, 2'b01);
            end else begin
               waitcyc++;
               tick();
            end
         end
         check("timeout fired", found, 1);
         tick();
         #1;
         check("timeout sticky",   timeout_o, 1);
         check("timeout idle",     busy_o,    0);
         s_rvalid_i = 1'b1;
         #1;
         check("timeout late rvalid", m_rvalid_o, 2'b00);
         s_rvalid_i = 1'b0;
         repeat (3) tick();
         check("timeout still sticky", timeout_o, 1);
      end
`endif

      // ---------------- randomized run vs. reference model ----------------
      do_reset();
      for (int k = 0; k < N; k++) begin
         pend[k]   = 1'b0;
         waited[k] = 0;
      end
      ptr_m      = 0;
      rd_out     = 1'b0;
      rd_owner   = 0;
      rd_delay   = 0;
      prev_busy  = 1'b0;
      prev_valid = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && $urandom_range(2) == 0) begin
               pend[k]    = 1'b1;
               waited[k]  = 0;
               addr_q[k]  = $urandom;
               wdata_q[k] = $urandom;
               wstrb_q[k] = ($urandom_range(1) == 0) ? '0 : SW'($urandom_range(15, 1));
            end
            m_valid_i[k] = pend[k];
         end
         s_ready_i = ($urandom_range(3) != 0);
         s_rdata_i = $urandom;
         resp_now  = 1'b0;
         if (rd_out) begin
            resp_now   = (rd_delay == 0);
            s_rvalid_i = resp_now;
            if (rd_delay > 0) rd_delay--;
         end else begin
            s_rvalid_i = ($urandom_range(7) == 0);
         end
         #1;

         if (!prev_busy) begin
            check("rand grant", grant_o, (prev_valid == '0) ? '0 : oh(rr(prev_valid, ptr_m)));
         end
         check("rand ready onehot0", $countones(m_ready_o) <= 1, 1);
         check("rand m_rvalid", m_rvalid_o, resp_now ? oh(rd_owner) : '0);
         if (resp_now) begin
            check("rand m_rdata", m_rdata_o, s_rdata_i);
            rd_out = 1'b0;
         end

         for (int k = 0; k < N; k++) begin
            if (m_ready_o[k]) begin
               check("rand ready to requester", pend[k], 1);
               if (pend[k]) begin
                  check("rand s_valid",  s_valid_o, 1);
                  check("rand s_addr",   s_addr_o,  addr_q[k]);
                  check("rand s_wdata",  s_wdata_o, wdata_q[k]);
                  check("rand s_wstrb",  s_wstrb_o, wstrb_q[k]);
                  check("rand owner",    grant_o,   oh(k));
                  check("rand fairness", waited[k] <= N - 1, 1);
                  for (int j = 0; j < N; j++) begin
                     if (j != k && pend[j]) waited[j]++;
                  end
                  pend[k] = 1'b0;
                  ptr_m   = (k + 1) % N;
                  if (wstrb_q[k] == '0) begin
                     rd_out   = 1'b1;
                     rd_owner = k;
                     rd_delay = $urandom_range(3);
                  end
               end
            end
         end
         prev_busy  = busy_o;
         prev_valid = m_valid_i;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
